// File: rtl/tm1638_pkg.sv
// TM1638 refresh sequencer: shared constants, FSM state and snapshot types.
// Used by tm1638_frame_seq and tm1638_byte_sel.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0     = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON   = 8'h88;
  localparam logic [7:0] CMD_DISP_OFF  = 8'h80;
  localparam int         SEQ_LEN       = 19;
  localparam logic [4:0] LAST_IDX      = 5'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_FIN     = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [63:0] digits;
    logic [7:0]  leds;
    logic [2:0]  bright;
    logic        disp_on;
  } snap_t;

endpackage

// File: rtl/tm1638_byte_sel.sv
// Combinational byte/last selector for the TM1638 refresh sequence.
// Maps sequence index 0..18 onto command, segment and LED bytes.
module tm1638_byte_sel
  import tm1638_pkg::*;
(
  input  logic [4:0] idx_i,
  input  snap_t      snap_i,
  output logic [7:0] data_o,
  output logic       last_o
);

  logic [3:0] off;
  logic [2:0] k;

  // idx 2..17 wraps to off 0..15 in four bits
  always_comb begin
    off    = idx_i[3:0] - 4'd2;
    k      = off[3:1];
    data_o = 8'h00;
    last_o = 1'b0;
    unique case (1'b1)
      (idx_i == 5'd0): begin
        data_o = CMD_DATA_AUTO;
        last_o = 1'b1;
      end
      (idx_i == 5'd1): begin
        data_o = CMD_ADDR0;
      end
      (idx_i >= LAST_IDX): begin
        data_o = snap_i.disp_on
               ? (CMD_DISP_ON | {5'b0, snap_i.bright})
               : CMD_DISP_OFF;
        last_o = 1'b1;
      end
      default: begin
        data_o = off[0]
               ? {7'b0, snap_i.leds[k]}
               : snap_i.digits[{k, 3'b000} +: 8];
        last_o = (idx_i == LAST_IDX - 5'd1);
      end
    endcase
  end

endmodule

// File: rtl/tm1638_frame_seq.sv
// TM1638 refresh sequencer: 19-byte frame stream over a rdy/busy handshake.
// Define TM1638_FRAME_SEQ_DIAG_EN to expose diag_state/diag_idx.
module tm1638_frame_seq
  import tm1638_pkg::*;
#(
  parameter int         DIGITS     = 8,
  parameter logic [2:0] DEF_BRIGHT = 3'd7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [8*DIGITS-1:0]          digits,
  input  logic [DIGITS-1:0]            leds,
  input  logic [$bits(DEF_BRIGHT)-1:0] bright,
  input  logic                         disp_on,
  input  logic                         busy,
  output logic                         data_rdy,
  output logic [7:0]                   data,
  output logic                         data_last,
  output logic                         seq_busy,
`ifdef TM1638_FRAME_SEQ_DIAG_EN
  output logic [2:0]                   diag_state,
  output logic [4:0]                   diag_idx,
`endif
  output logic                         done
);

  seq_state_t state_q;
  logic [4:0] idx_q;
  snap_t      snap_q;
  snap_t      snap_d;
  logic       rdy_q;
  logic [7:0] data_q;
  logic       last_q;
  logic       sbusy_q;
  logic       done_q;
  logic [7:0] sel_data;
  logic       sel_last;

  assign snap_d = {digits, leds, bright, disp_on};

  tm1638_byte_sel u_sel (
    .idx_i  (idx_q),
    .snap_i (snap_q),
    .data_o (sel_data),
    .last_o (sel_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      rdy_q   <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      sbusy_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_q  <= snap_d;
            idx_q   <= '0;
            sbusy_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!busy) begin
            rdy_q   <= 1'b1;
            data_q  <= sel_data;
            last_q  <= sel_last;
            state_q <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (busy) state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!busy) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_FIN: begin
          sbusy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_rdy  = rdy_q;
  assign data      = data_q;
  assign data_last = last_q;
  assign seq_busy  = sbusy_q;
  assign done      = done_q;

`ifdef TM1638_FRAME_SEQ_DIAG_EN
  assign diag_state = state_q;
  assign diag_idx   = idx_q;
`endif

endmodule

// File: tb/tb_tm1638_frame_seq.sv
// Self-checking bench for tm1638_frame_seq with a model transmitter.
// Optional diag checks follow TM1638_FRAME_SEQ_DIAG_EN.
module tb_tm1638_frame_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] digits = '0;
  logic [7:0]  leds = '0;
  logic [2:0]  bright = '0;
  logic        disp_on = 1'b0;
  logic        busy = 1'b0;
  logic        data_rdy;
  logic [7:0]  data;
  logic        data_last;
  logic        seq_busy;
  logic        done;
`ifdef TM1638_FRAME_SEQ_DIAG_EN
  logic [2:0]  diag_state;
  logic [4:0]  diag_idx;
`endif

  always #5 clk = ~clk;

  tm1638_frame_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .digits     (digits),
    .leds       (leds),
    .bright     (bright),
    .disp_on    (disp_on),
    .busy       (busy),
    .data_rdy   (data_rdy),
    .data       (data),
    .data_last  (data_last),
    .seq_busy   (seq_busy),
`ifdef TM1638_FRAME_SEQ_DIAG_EN
    .diag_state (diag_state),
    .diag_idx   (diag_idx),
`endif
    .done       (done)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_b [19];
  logic       exp_l [19];
  int pos = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [7:0] cap_b [$];
  logic       cap_l [$];
  logic hold_busy = 1'b0;
  int tx_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected stream from the display rules, not from the RTL structure
  task automatic build(input logic [63:0] d, input logic [7:0] l,
                       input logic [2:0] b, input logic on);
    exp_b[0] = 8'h40;
    exp_b[1] = 8'hC0;
    for (int k = 0; k < 8; k++) begin
      exp_b[2 + 2*k] = d[8*k +: 8];
      exp_b[3 + 2*k] = {7'b0, l[k]};
    end
    exp_b[18] = on ? (8'h88 + {5'b0, b}) : 8'h80;
    for (int i = 0; i < 19; i++)
      exp_l[i] = (i == 0) || (i == 17) || (i == 18);
    pos = 0;
    cap_b.delete();
    cap_l.delete();
  endtask

  // Transmitter model and per-cycle compare
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      tx_cnt = 0;
      busy = 1'b0;
    end else begin
      if (data_rdy) begin
        chk("rdy_while_busy", {31'b0, busy}, 0);
        if (pos >= 19) begin
          checks++;
          failures++;
          $display("FAIL extra_rdy: got byte %0h expected none", data);
        end else begin
          chk($sformatf("data[%0d]", pos), {24'b0, data}, {24'b0, exp_b[pos]});
          chk($sformatf("last[%0d]", pos), {31'b0, data_last}, {31'b0, exp_l[pos]});
        end
`ifdef TM1638_FRAME_SEQ_DIAG_EN
        chk("diag_idx", {27'b0, diag_idx}, pos);
        chk("diag_state_hi", {29'b0, diag_state}, 2);
`endif
        cap_b.push_back(data);
        cap_l.push_back(data_last);
        pos++;
        tx_cnt = 11;
      end
      if (done) begin
        done_cnt++;
        chk("done_pos", pos, 19);
`ifdef TM1638_FRAME_SEQ_DIAG_EN
        chk("diag_idx_fin", {27'b0, diag_idx}, 18);
        chk("diag_state_fin", {29'b0, diag_state}, 4);
`endif
      end
      if (hold_busy) busy = 1'b1;
      else if (tx_cnt > 0) begin
        busy = 1'b1;
        tx_cnt--;
      end else busy = 1'b0;
    end
  end

  task automatic run_start(input logic [63:0] d, input logic [7:0] l,
                           input logic [2:0] b, input logic on);
    build(d, l, b, on);
    @(negedge clk);
    digits = d;
    leds = l;
    bright = b;
    disp_on = on;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("seq_busy_run", {31'b0, seq_busy}, 1);
  endtask

  task automatic wait_pos(input int target, input int budget);
    int n = 0;
    while (pos < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pos_timeout", {31'b0, pos >= target}, 1);
  endtask

  task automatic finish_seq(input int budget);
    int n = 0;
    while (done_cnt == exp_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    exp_done++;
    repeat (20) @(negedge clk);
    chk("done_count", done_cnt, exp_done);
    chk("seq_busy_idle", {31'b0, seq_busy}, 0);
    chk("byte_count", cap_b.size(), 19);
  endtask

  logic [7:0] lit [19] = '{8'h40, 8'hC0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02,
                           8'h01, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h01,
                           8'h06, 8'h00, 8'h07, 8'h01, 8'h8D};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'b0, data_rdy}, 0);
    chk("rst_data", {24'b0, data}, 0);
    chk("rst_last", {31'b0, data_last}, 0);
    chk("rst_sbusy", {31'b0, seq_busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_start(64'h0706050403020100, 8'b10100101, 3'd5, 1'b1);
    finish_seq(3000);
    if (cap_b.size() == 19) begin
      for (int i = 0; i < 19; i++) begin
        chk($sformatf("lit_byte[%0d]", i), {24'b0, cap_b[i]}, {24'b0, lit[i]});
        chk($sformatf("lit_last[%0d]", i), {31'b0, cap_l[i]},
            (i == 0 || i == 17 || i == 18) ? 32'd1 : 32'd0);
      end
    end

    // start coinciding with FIN must be ignored
    run_start(64'h1122334455667788, 8'h3C, 3'd7, 1'b0);
    begin
      int n = 0;
      while (!done && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("fin_seen", {31'b0, done}, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    exp_done++;
    repeat (30) @(negedge clk);
    chk("fin_start_ignored", {31'b0, seq_busy}, 0);
    chk("fin_done_count", done_cnt, exp_done);
    chk("final_off", {24'b0, cap_b[cap_b.size()-1]}, 32'h80);

    hold_busy = 1'b1;
    run_start(64'hDEADBEEF01234567, 8'h81, 3'd2, 1'b1);
    repeat (50) @(negedge clk);
    chk("no_rdy_hold", pos, 0);
    hold_busy = 1'b0;
    finish_seq(3000);

    run_start(64'hA5A55A5AF00F0FF0, 8'h6E, 3'd0, 1'b1);
    wait_pos(5, 1000);
    digits = 64'h0;
    leds = 8'h00;
    bright = 3'd3;
    disp_on = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_seq(3000);

    run_start(64'h8877665544332211, 8'hF0, 3'd4, 1'b1);
    wait_pos(9, 1000);
    #3 rst = 1'b0;
    #1;
    chk("arst_rdy", {31'b0, data_rdy}, 0);
    chk("arst_data", {24'b0, data}, 0);
    chk("arst_last", {31'b0, data_last}, 0);
    chk("arst_sbusy", {31'b0, seq_busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_rdy_after_rst", pos, 9);
    run_start(64'h0F0E0D0C0B0A0908, 8'h55, 3'd6, 1'b1);
    finish_seq(3000);
    if (cap_b.size() > 0)
      chk("restart_first", {24'b0, cap_b[0]}, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
